// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable divider: controller states and defaults.
package clk_div_pkg;

  // Controller states: wait for the MMCM to lock, make sure the lock holds, then run.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Default number of consecutive locked cycles required before the channels start.
  localparam int LOCK_CNT_DEFAULT = 256;

  // Upper bound on the number of divider channels a single instance supports.
  localparam int NUM_CH_MAX = 8;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow ratio and registered ce/sq outputs.
// The outputs are computed from next-state values so that ce_o/sq_o line up with
// the counter register rather than lagging it by a cycle.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o,
  output logic             sq_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             active_q, active_d;
  logic             ce_q, ce_d;
  logic             sq_q, sq_d;

  logic [DIV_W-1:0] ratio_q;
  logic [DIV_W-1:0] ratio_d;
  logic [DIV_W-1:0] half_d;
  logic             wrap;
  logic             restart;

  // A programmed ratio of zero behaves like a ratio of one.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] n);
    return (n == '0) ? DIV_W'(1) : n;
  endfunction

  // Next counter, shadow ratio and strobe values for this channel.
  always_comb begin
    active_d = run_i & en_i;
    ratio_q  = eff_ratio(shadow_q);
    wrap     = (cnt_q == (ratio_q - DIV_W'(1)));
    // A new period starts after an idle cycle, on a realign, or at the wrap.
    restart  = ~active_q | sync_i | wrap;

    shadow_d = shadow_q;
    if (restart) begin
      shadow_d = div_i;
    end

    cnt_d = cnt_q;
    if (!active_d || restart) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    ratio_d = eff_ratio(shadow_d);
    half_d  = (ratio_d >> 1) + DIV_W'(ratio_d[0]);

    ce_d = active_d & (cnt_d == '0);
    sq_d = active_d & (ratio_d != DIV_W'(1)) & (cnt_d < half_d);
  end

  // Channel state registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= 1'b0;
      ce_q     <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ce_q     <= ce_d;
      sq_q     <= sq_d;
    end
  end

  assign ce_o = ce_q;
  assign sq_o = sq_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator running off an MMCM output clock.
// A small controller holds every channel idle until the MMCM lock has been
// stable for LOCK_CNT cycles, then releases all channels phase-aligned.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    locked_i,
  input  logic                    sync_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       sq_o,
  output logic                    ready_o,
  output logic                    rst_sync_n_o
);

  localparam int LCW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  logic           locked_meta_q;
  logic           locked_sync_q;
  state_e         state_q, state_d;
  logic [LCW-1:0] stab_cnt_q, stab_cnt_d;
  logic           run_q;
  logic           run_d;
  logic           sync_run;

  // Two-flop synchronizer for the asynchronous MMCM lock flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      locked_meta_q <= locked_i;
      locked_sync_q <= locked_meta_q;
    end
  end

  // Controller next state: the stability count reaches LOCK_CNT-1 on the same
  // edge that enters RUN, so a clean lock gives ready after 2 + LOCK_CNT edges.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = '0;
        if (locked_sync_q) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_sync_q) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == LCW'(LOCK_CNT - 2)) begin
          state_d    = RUN;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + LCW'(1);
        end
      end
      RUN: begin
        stab_cnt_d = '0;
        if (!locked_sync_q) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Controller state and stability counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= WAIT_LOCK;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // Channels look at the next state so their registered strobes appear in the
  // first RUN cycle; a realign request only counts while already running.
  assign run_q    = (state_q == RUN);
  assign run_d    = (state_d == RUN);
  assign sync_run = run_q & sync_i;

  assign ready_o      = run_q;
  assign rst_sync_n_o = run_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .run_i   (run_d),
      .sync_i  (sync_run),
      .en_i    (en_i[k]),
      .div_i   (div_i[k*DIV_W +: DIV_W]),
      .ce_o    (ce_o[k]),
      .sq_o    (sq_o[k])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: lock sequencing, ratios, ratio change,
// realign, lock loss and asynchronous reset.
module tb_clk_div_gen;

   localparam int NUM_CH   = 4;
   localparam int DIV_W    = 16;
   localparam int LOCK_CNT = 16;

   logic                    clock;
   logic                    rstN;
   logic                    locked;
   logic                    syncPulse;
   logic [NUM_CH-1:0]       enable;
   logic [NUM_CH*DIV_W-1:0] divVec;
   logic [NUM_CH-1:0]       ceOut;
   logic [NUM_CH-1:0]       sqOut;
   logic                    ready;
   logic                    rstSyncN;

   int checks = 0;
   int errors = 0;

   clk_div_gen #(
      .NUM_CH   (NUM_CH),
      .DIV_W    (DIV_W),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk_i        (clock),
      .rst_n_i      (rstN),
      .locked_i     (locked),
      .sync_i       (syncPulse),
      .en_i         (enable),
      .div_i        (divVec),
      .ce_o         (ceOut),
      .sq_o         (sqOut),
      .ready_o      (ready),
      .rst_sync_n_o (rstSyncN)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance by n rising edges; inputs are driven and outputs sampled on falling edges.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic setDiv(input int ch, input int value);
      divVec[ch*DIV_W +: DIV_W] = DIV_W'(value);
   endtask

   function automatic logic expCe(input int t, input int m);
      return (t % m) == 0;
   endfunction

   function automatic logic expSq(input int t, input int m);
      return (m > 1) && ((t % m) < ((m + 1) / 2));
   endfunction

   initial begin
      int ratios [NUM_CH];
      logic [NUM_CH-1:0] ceExp;
      logic [NUM_CH-1:0] sqExp;

      rstN      = 1'b0;
      locked    = 1'b1;
      syncPulse = 1'b0;
      enable    = 4'b1111;
      divVec    = '0;
      ratios    = '{1, 2, 3, 8};
      for (int k = 0; k < NUM_CH; k++) setDiv(k, ratios[k]);

      // Reset state
      #2;
      checkOutput("reset_ready", {31'd0, ready}, 32'd0);
      checkOutput("reset_rstsync", {31'd0, rstSyncN}, 32'd0);
      checkOutput("reset_ce_sq", {24'd0, ceOut, sqOut}, 32'd0);

      // Lock sequencing: ready on the 18th edge after release, not before
      @(negedge clock);
      rstN = 1'b1;
      applyStimulus(17);
      checkOutput("pre_ready_outputs", {23'd0, ready, ceOut, sqOut}, 32'd0);
      applyStimulus(1);
      checkOutput("ready_at_18", {31'd0, ready}, 32'd1);
      checkOutput("rstsync_at_18", {31'd0, rstSyncN}, 32'd1);

      // Ratios 1,2,3,8 all enabled, phase-aligned from the first RUN cycle
      for (int t = 0; t < 24; t++) begin
         if (t > 0) applyStimulus(1);
         for (int k = 0; k < NUM_CH; k++) begin
            ceExp[k] = expCe(t, ratios[k]);
            sqExp[k] = expSq(t, ratios[k]);
         end
         checkOutput($sformatf("ratios_ce_t%0d", t), {28'd0, ceOut}, {28'd0, ceExp});
         checkOutput($sformatf("ratios_sq_t%0d", t), {28'd0, sqOut}, {28'd0, sqExp});
      end

      // Disabling forces outputs low
      enable = 4'b0000;
      applyStimulus(1);
      checkOutput("disabled_outputs", {24'd0, ceOut, sqOut}, 32'd0);

      // Ch0 ratio 8 changed to 4 while its counter holds 3
      setDiv(0, 8);
      enable = 4'b0001;
      applyStimulus(1);
      checkOutput("chg_ce_t0", {28'd0, ceOut}, 32'd1);
      for (int t = 1; t <= 16; t++) begin
         applyStimulus(1);
         ceExp[0] = (t == 8) || (t == 12) || (t == 16);
         sqExp[0] = (t < 8) ? (t < 4) : (((t - 8) % 4) < 2);
         checkOutput($sformatf("chg_ce_t%0d", t), {28'd0, ceOut}, {31'd0, ceExp[0]});
         checkOutput($sformatf("chg_sq_t%0d", t), {28'd0, sqOut}, {31'd0, sqExp[0]});
         if (t == 3) setDiv(0, 4);
      end

      // Realign of ratios 5 and 7 mid-period
      enable = 4'b0000;
      applyStimulus(1);
      setDiv(0, 5);
      setDiv(1, 7);
      enable = 4'b0011;
      applyStimulus(1);
      checkOutput("sync_start_ce", {28'd0, ceOut}, 32'h3);
      applyStimulus(3);
      checkOutput("sync_mid_ce", {28'd0, ceOut}, 32'h0);
      syncPulse = 1'b1;
      applyStimulus(1);
      syncPulse = 1'b0;
      checkOutput("sync_s0_ce", {28'd0, ceOut}, 32'h3);
      for (int s = 1; s < 15; s++) begin
         applyStimulus(1);
         ceExp = {2'b00, expCe(s, 7), expCe(s, 5)};
         checkOutput($sformatf("sync_ce_s%0d", s), {28'd0, ceOut}, {28'd0, ceExp});
      end

      // Lock loss in RUN: outputs drop on the third edge
      enable = 4'b0000;
      applyStimulus(1);
      setDiv(0, 1);
      enable = 4'b0001;
      applyStimulus(1);
      checkOutput("m1_ce", {28'd0, ceOut}, 32'h1);
      locked = 1'b0;
      applyStimulus(1);
      checkOutput("unlock_e1", {27'd0, ready, ceOut}, 32'h11);
      applyStimulus(1);
      checkOutput("unlock_e2", {27'd0, ready, ceOut}, 32'h11);
      applyStimulus(1);
      checkOutput("unlock_e3", {22'd0, ready, rstSyncN, ceOut, sqOut}, 32'd0);

      // Glitch in STABLE at count 10 forces a full recount
      locked = 1'b1;
      applyStimulus(11);
      locked = 1'b0;
      applyStimulus(1);
      locked = 1'b1;
      applyStimulus(6);
      checkOutput("glitch_no_ready_18", {31'd0, ready}, 32'd0);
      applyStimulus(11);
      checkOutput("glitch_no_ready_29", {31'd0, ready}, 32'd0);
      applyStimulus(1);
      checkOutput("glitch_ready_30", {27'd0, ready, ceOut}, 32'h11);

      // Asynchronous reset mid-RUN, no strobe after release
      rstN = 1'b0;
      #1;
      checkOutput("async_reset", {22'd0, ready, rstSyncN, ceOut, sqOut}, 32'd0);
      applyStimulus(2);
      rstN = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1);
         checkOutput($sformatf("post_reset_e%0d", i), {23'd0, ready, ceOut, sqOut}, 32'd0);
      end
      applyStimulus(1);
      checkOutput("post_reset_ready", {27'd0, ready, ceOut}, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
